// File: rtl/road_track_engine.sv
// Road-edge generator for the stay-on-road game: circular edge buffer scrolled by
// line_tick, scripted bends scaled by level, road narrowing and a car collision check.
//
// state  | meaning
// S_FILL | writing the initial straight road, one buffer row per clock
// S_RUN  | scrolling one row per line_tick, checking the car's front row
// S_DEAD | collision latched, edges/level/distance frozen until restart
module road_track_engine #(
  parameter int ROWS           = 480,
  parameter int XW             = 10,
  parameter int CENTER         = 464,
  parameter int HALF_W_INIT    = 50,
  parameter int HALF_W_MIN     = 24,
  parameter int CX_MIN         = 80,
  parameter int CX_MAX         = 720,
  parameter int SCRIPT_LEN     = 4,
  parameter int LEVEL_MAX      = 8,
  parameter int ROWS_PER_LEVEL = 56,
  parameter int CAR_W          = 30,
  parameter int CAR_H          = 30
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          line_tick,
  input  logic          restart,
  input  logic [XW-1:0] car_x,
  input  logic [8:0]    car_y,
  input  logic [8:0]    rd_row,
  output logic [XW-1:0] rd_left,
  output logic [XW-1:0] rd_right,
  output logic          dead,
  output logic          busy,
  output logic [3:0]    level,
  output logic [15:0]   distance
);

  localparam int AW = $clog2(ROWS);
  localparam int PW = (SCRIPT_LEN > 1) ? $clog2(SCRIPT_LEN) : 1;
  localparam int LW = (ROWS_PER_LEVEL > 1) ? $clog2(ROWS_PER_LEVEL) : 1;

  localparam logic [AW-1:0]      LAST_ROW     = AW'(ROWS - 1);
  localparam logic [AW:0]        LAST_ROW_X   = (AW+1)'(ROWS - 1);
  localparam logic [AW+1:0]      ROWS_X       = (AW+2)'(ROWS);
  localparam logic [AW:0]        FRONT_OFS    = (AW+1)'(CAR_H - 1);
  localparam logic [PW-1:0]      PTR_LAST     = PW'(SCRIPT_LEN - 1);
  localparam logic [LW-1:0]      LVL_CNT_LAST = LW'(ROWS_PER_LEVEL - 1);
  localparam logic [3:0]         LVL_TOP      = 4'(LEVEL_MAX);
  localparam logic [XW-1:0]      CENTER_X     = XW'(CENTER);
  localparam logic [XW-1:0]      HW_INIT      = XW'(HALF_W_INIT);
  localparam logic [XW-1:0]      HW_MIN       = XW'(HALF_W_MIN);
  localparam logic signed [XW:0] CX_LO        = (XW+1)'(CX_MIN);
  localparam logic signed [XW:0] CX_HI        = (XW+1)'(CX_MAX);
  localparam logic [XW:0]        CAR_SPAN     = (XW+1)'(CAR_W - 1);
  localparam logic [2*XW-1:0]    FILL_WORD    = {CENTER_X - HW_INIT, CENTER_X + HW_INIT};

  typedef enum logic [1:0] {S_FILL, S_RUN, S_DEAD} state_t;

  state_t state, state_nx;

  logic                 started;
  logic [AW-1:0]        fill_cnt;
  logic [AW-1:0]        head;
  logic [AW-1:0]        head_dec;
  logic [XW-1:0]        centre;
  logic [XW-1:0]        centre_nx;
  logic signed [XW:0]   centre_sum;
  logic signed [XW:0]   delta_x;
  logic signed [XW:0]   delta_x_nx;
  logic signed [XW:0]   dlt_s;
  logic signed [XW:0]   lvl_s;
  logic [7:0]           rows_left;
  logic [7:0]           rows_left_nx;
  logic [7:0]           two_lvl;
  logic signed [7:0]    seg_delta;
  logic [7:0]           seg_rows;
  logic [PW-1:0]        script_ptr;
  logic [LW-1:0]        lvl_cnt;
  logic [XW-1:0]        hw_drop;
  logic [XW-1:0]        half_w;
  logic [2*XW-1:0]      run_word;
  logic                 tick_run;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [2*XW-1:0]      wr_data;
  logic [AW:0]          front_sum;
  logic [AW-1:0]        front_row;
  logic [AW-1:0]        col_addr;
  logic [AW-1:0]        rd_addr;
  logic [2*XW-1:0]      col_data;
  logic [XW:0]          car_right;
  logic                 collide;
  logic                 chk1, chk2;

  logic [2*XW-1:0] mem [ROWS];

  function automatic logic signed [7:0] script_delta(input logic [PW-1:0] idx);
    if (idx == PW'(1))      return 8'sd3;
    else if (idx == PW'(3)) return -8'sd3;
    else                    return 8'sd0;
  endfunction

  function automatic logic [7:0] script_rows(input logic [PW-1:0] idx);
    return idx[0] ? 8'd18 : 8'd10;
  endfunction

  // Logical row -> buffer address, (hd + r) mod ROWS.
  function automatic logic [AW-1:0] map_row(input logic [AW-1:0] hd, input logic [8:0] r);
    logic [AW+1:0] s;
    s = (AW+2)'(hd) + (AW+2)'(r);
    if (s >= ROWS_X) s = s - ROWS_X;
    if (s >= ROWS_X) s = s - ROWS_X;
    return s[AW-1:0];
  endfunction

  assign busy     = (state != S_RUN);
  assign tick_run = (state == S_RUN) && line_tick && !restart;
  assign head_dec = (head == '0) ? LAST_ROW : head - AW'(1);

  always_comb begin
    seg_delta    = script_delta(script_ptr);
    seg_rows     = script_rows(script_ptr);
    lvl_s        = {{(XW-3){1'b0}}, level};
    dlt_s        = {{(XW-7){seg_delta[7]}}, seg_delta};
    two_lvl      = {3'b000, level, 1'b0};
    delta_x_nx   = delta_x;
    rows_left_nx = rows_left - 8'd1;
    if (rows_left == 8'd0) begin
      if (seg_delta > 8'sd0)      delta_x_nx = dlt_s + lvl_s;
      else if (seg_delta < 8'sd0) delta_x_nx = dlt_s - lvl_s;
      else                        delta_x_nx = '0;
      rows_left_nx = (seg_rows > two_lvl) ? seg_rows - two_lvl : 8'd1;
    end
    centre_sum = signed'({1'b0, centre}) + delta_x_nx;
    if (centre_sum < CX_LO)      centre_nx = CX_LO[XW-1:0];
    else if (centre_sum > CX_HI) centre_nx = CX_HI[XW-1:0];
    else                         centre_nx = centre_sum[XW-1:0];
    hw_drop  = (XW'(level) - XW'(1)) << 1;
    half_w   = (HW_INIT > hw_drop + HW_MIN) ? HW_INIT - hw_drop : HW_MIN;
    // Row written on a tick uses the centre from before this tick's move.
    run_word = {centre - half_w, centre + half_w};
  end

  always_comb begin
    front_sum = (AW+1)'(car_y) + FRONT_OFS;
    front_row = (front_sum > LAST_ROW_X) ? LAST_ROW : front_sum[AW-1:0];
    col_addr  = map_row(head, 9'(front_row));
    rd_addr   = map_row(head, rd_row);
    car_right = {1'b0, car_x} + CAR_SPAN;
    collide   = ({1'b0, car_x} < {1'b0, col_data[2*XW-1:XW]}) ||
                (car_right > {1'b0, col_data[XW-1:0]});
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = fill_cnt;
    wr_data = FILL_WORD;
    if (state == S_FILL && started && !restart) begin
      wr_en = 1'b1;
    end else if (tick_run) begin
      wr_en   = 1'b1;
      wr_addr = head_dec;
      wr_data = run_word;
    end
  end

  // Buffer has no reset; its contents are rebuilt by FILL.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    col_data <= mem[col_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_left  <= '0;
      rd_right <= '0;
    end else begin
      {rd_left, rd_right} <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FILL;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FILL: if (!restart && started && fill_cnt == LAST_ROW) state_nx = S_RUN;
      S_RUN: begin
        if (restart)              state_nx = S_FILL;
        else if (chk2 && collide) state_nx = S_DEAD;
      end
      S_DEAD: if (restart) state_nx = S_FILL;
      default: state_nx = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk1 <= 1'b0;
      chk2 <= 1'b0;
      dead <= 1'b0;
    end else if (restart) begin
      chk1 <= 1'b0;
      chk2 <= 1'b0;
      dead <= 1'b0;
    end else begin
      chk1 <= tick_run;
      chk2 <= chk1 && (state == S_RUN);
      if (state == S_RUN && chk2 && collide) dead <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started    <= 1'b0;
      fill_cnt   <= '0;
      head       <= '0;
      centre     <= CENTER_X;
      delta_x    <= '0;
      rows_left  <= '0;
      script_ptr <= '0;
      lvl_cnt    <= '0;
      level      <= 4'd1;
      distance   <= '0;
    end else begin
      started <= 1'b1;
      if (restart) begin
        fill_cnt   <= '0;
        head       <= '0;
        centre     <= CENTER_X;
        delta_x    <= '0;
        rows_left  <= '0;
        script_ptr <= '0;
        lvl_cnt    <= '0;
        level      <= 4'd1;
        distance   <= '0;
      end else begin
        if (state == S_FILL && started)
          fill_cnt <= (fill_cnt == LAST_ROW) ? '0 : fill_cnt + AW'(1);
        if (tick_run) begin
          head      <= head_dec;
          centre    <= centre_nx;
          delta_x   <= delta_x_nx;
          rows_left <= rows_left_nx;
          if (rows_left == 8'd0)
            script_ptr <= (script_ptr == PTR_LAST) ? '0 : script_ptr + PW'(1);
          // lvl_cnt tracks distance mod ROWS_PER_LEVEL while distance is counting.
          if (distance != 16'hFFFF) begin
            distance <= distance + 16'd1;
            if (lvl_cnt == LVL_CNT_LAST) begin
              lvl_cnt <= '0;
              if (level < LVL_TOP) level <= level + 4'd1;
            end else begin
              lvl_cnt <= lvl_cnt + LW'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_road_track_engine.sv
// Self-checking bench for road_track_engine: directed vector table, multi-cycle
// corner sequences, and randomized ticks against a queue-based road model.
module tb_road_track_engine;

  logic       clk = 1'b0;
  logic       rst, line_tick, restart;
  logic [9:0] car_x;
  logic [8:0] car_y, rd_row;
  logic [9:0] rd_left, rd_right;
  logic       dead, busy;
  logic [3:0] level;
  logic [15:0] distance;

  road_track_engine dut (
    .clk(clk), .rst(rst), .line_tick(line_tick), .restart(restart),
    .car_x(car_x), .car_y(car_y), .rd_row(rd_row),
    .rd_left(rd_left), .rd_right(rd_right), .dead(dead), .busy(busy),
    .level(level), .distance(distance)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: road as a list of logical rows, row 0 newest.
  int mq_l[$];
  int mq_r[$];
  int m_centre, m_dx, m_rows_left, m_ptr, m_dist, m_level;
  bit m_dead;
  int scr_d[4] = '{0, 3, 0, -3};
  int scr_r[4] = '{10, 18, 10, 18};

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void model_refill();
    mq_l.delete();
    mq_r.delete();
    for (int i = 0; i < 480; i++) begin
      mq_l.push_back(464 - 50);
      mq_r.push_back(464 + 50);
    end
    m_centre = 464; m_dx = 0; m_rows_left = 0; m_ptr = 0;
    m_dist = 0; m_level = 1; m_dead = 0;
  endfunction

  function automatic void model_tick(input int cx, input int cy);
    int d, sgn, hw, nc, f;
    if (m_rows_left == 0) begin
      d = scr_d[m_ptr];
      sgn = (d > 0) ? 1 : ((d < 0) ? -1 : 0);
      m_dx = d + sgn * m_level;
      m_rows_left = imax(scr_r[m_ptr] - 2 * m_level, 1);
      m_ptr = (m_ptr + 1) % 4;
    end else begin
      m_rows_left--;
    end
    hw = imax(50 - 2 * (m_level - 1), 24);
    mq_l.push_front(m_centre - hw);
    mq_r.push_front(m_centre + hw);
    void'(mq_l.pop_back());
    void'(mq_r.pop_back());
    nc = m_centre + m_dx;
    if (nc < 80) nc = 80;
    if (nc > 720) nc = 720;
    m_centre = nc;
    if (m_dist < 65535) m_dist++;
    if (m_dist % 56 == 0 && m_dist != 0 && m_level < 8) m_level++;
    f = (cy + 29 > 479) ? 479 : cy + 29;
    if (cx < mq_l[f] || cx + 29 > mq_r[f]) m_dead = 1;
  endfunction

  task automatic tick();
    @(negedge clk);
    line_tick = 1'b1;
    if (!m_dead) model_tick(int'(car_x), int'(car_y));
    @(negedge clk);
    line_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic read_row(input int r, output int l, output int rr);
    @(negedge clk);
    rd_row = 9'(r);
    @(negedge clk);
    l = int'(rd_left);
    rr = int'(rd_right);
  endtask

  task automatic check_model_row(input int r);
    int l, rr;
    read_row(r, l, rr);
    check("row_left", l, mq_l[r % 480]);
    check("row_right", rr, mq_r[r % 480]);
  endtask

  task automatic check_model_state();
    check("dead_vs_model", int'(dead), int'(m_dead));
    check("distance_vs_model", int'(distance), m_dist);
    check("level_vs_model", int'(level), m_level);
  endtask

  task automatic release_and_fill();
    @(negedge clk);
    rst = 1'b1;
    model_refill();
    for (int i = 1; i <= 481; i++) begin
      @(posedge clk);
      #1;
      if (i == 480) check("powerup_busy_480", int'(busy), 1);
      if (i == 481) check("powerup_busy_481", int'(busy), 0);
    end
  endtask

  task automatic do_restart(input bit with_tick);
    @(negedge clk);
    restart = 1'b1;
    line_tick = with_tick;
    @(negedge clk);
    restart = 1'b0;
    line_tick = 1'b0;
    model_refill();
    check("restart_busy", int'(busy), 1);
    if (with_tick) check("restart_tick_distance", int'(distance), 0);
    for (int i = 1; i <= 480; i++) begin
      @(posedge clk);
      #1;
      if (i == 479) check("refill_busy_479", int'(busy), 1);
      if (i == 480) check("refill_busy_480", int'(busy), 0);
    end
    check("refill_dead", int'(dead), 0);
    check("refill_level", int'(level), 1);
    check("refill_distance", int'(distance), 0);
  endtask

  task automatic check_reset_values();
    check("rst_dead", int'(dead), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_level", int'(level), 1);
    check("rst_distance", int'(distance), 0);
    check("rst_rd_left", int'(rd_left), 0);
    check("rst_rd_right", int'(rd_right), 0);
  endtask

  typedef struct {
    int ticks;
    int row;
    int exp_l;
    int exp_r;
    int exp_dist;
    int exp_lvl;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int l, rr, f, base, w;

    vecs[0]  = '{0,  0,   414, 514, 0,  1};
    vecs[1]  = '{0,  240, 414, 514, 0,  1};
    vecs[2]  = '{0,  479, 414, 514, 0,  1};
    vecs[3]  = '{10, 0,   414, 514, 10, 1};
    vecs[4]  = '{0,  10,  414, 514, 10, 1};
    vecs[5]  = '{1,  0,   418, 518, 11, 1};
    vecs[6]  = '{1,  0,   422, 522, 12, 1};
    vecs[7]  = '{0,  1,   418, 518, 12, 1};
    vecs[8]  = '{14, 0,   478, 578, 26, 1};
    vecs[9]  = '{30, 0,   414, 514, 56, 2};
    vecs[10] = '{1,  0,   416, 512, 57, 2};
    vecs[11] = '{0,  1,   414, 514, 57, 2};

    rst = 1'b0; line_tick = 1'b0; restart = 1'b0;
    car_x = 10'd449; car_y = 9'd375; rd_row = 9'd0;
    model_refill();
    repeat (3) @(negedge clk);
    check_reset_values();
    release_and_fill();

    for (int i = 0; i < 12; i++) begin
      repeat (vecs[i].ticks) tick();
      read_row(vecs[i].row, l, rr);
      check("vec_left", l, vecs[i].exp_l);
      check("vec_right", rr, vecs[i].exp_r);
      check("vec_distance", int'(distance), vecs[i].exp_dist);
      check("vec_level", int'(level), vecs[i].exp_lvl);
      check("vec_dead", int'(dead), 0);
    end

    // Level saturation; the front row stays on fill data until tick 404.
    repeat (334) tick();
    check("level_before_max", int'(level), 7);
    tick();
    check("level_at_max", int'(level), 8);
    check("distance_392", int'(distance), 392);
    tick();
    read_row(0, l, rr);
    check("min_width_level8", rr - l, 72);
    for (int i = 0; i < 55; i++) begin
      car_x = 10'(mq_l[403] + 2);
      tick();
    end
    check("level_stays_max", int'(level), 8);
    check("distance_448", int'(distance), 448);
    check("no_dead_448", int'(dead), 0);

    do_restart(1'b0);

    // Collision timing: dead rises on the second edge after the tick sample.
    car_x = 10'd400; car_y = 9'd375;
    @(negedge clk);
    line_tick = 1'b1;
    model_tick(400, 375);
    @(posedge clk); #1;
    check("dead_edge0", int'(dead), 0);
    @(negedge clk);
    line_tick = 1'b0;
    @(posedge clk); #1;
    check("dead_edge1", int'(dead), 0);
    @(posedge clk); #1;
    check("dead_edge2", int'(dead), 1);
    check("dead_busy", int'(busy), 1);
    check("model_agrees_dead", int'(dead), int'(m_dead));
    car_x = 10'd449;
    repeat (3) tick();
    check("dead_frozen_distance", int'(distance), 1);
    check("dead_frozen_level", int'(level), 1);
    check("dead_held", int'(dead), 1);
    do_restart(1'b0);

    repeat (2) tick();
    check("pre_abort_distance", int'(distance), 2);
    do_restart(1'b1);

    // Asynchronous reset mid-RUN.
    repeat (3) tick();
    read_row(0, l, rr);
    check("pre_reset_left", l, 414);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_values();
    repeat (2) @(negedge clk);
    release_and_fill();

    // Asynchronous reset mid-FILL.
    do_restart(1'b0);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    repeat (200) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_values();
    repeat (2) @(negedge clk);
    release_and_fill();

    // Randomized ticks against the model.
    for (int n = 0; n < 200; n++) begin
      if (m_dead) do_restart(1'b0);
      car_y = 9'($urandom_range(0, 511));
      if (n % 10 == 0) car_y = 9'($urandom_range(450, 511));
      f = (int'(car_y) + 29 > 479) ? 479 : int'(car_y) + 29;
      base = mq_l[f - 1];
      w = mq_r[f - 1] - base;
      car_x = 10'(base - 2 + int'($urandom_range(0, w - 25)));
      if ($urandom_range(0, 7) == 0) car_x = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 19) == 0) begin
        do_restart(1'b1);
      end else begin
        tick();
        check_model_state();
      end
      check_model_row(int'($urandom_range(0, 511)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/road_track_engine.md
# road_track_engine

Parametrised road-edge generator and collision checker for the stay-on-road game. It replaces the per-clock shift of two 480-entry edge arrays with a circular edge buffer that advances once per `line_tick`. Road segments come from a scripted bend table that scales with difficulty, and the road narrows as the level rises. The block sits between the VGA timing generator (ticks and read addresses) and the pixel mux / car controller, which consume the edges, `dead`, `level` and `distance`.

## Interface
Parameters:
- `ROWS`, 480: visible rows, which is also the buffer depth.
- `XW`, 10: width of all x coordinates.
- `CENTER`, 464: initial road centre x.
- `HALF_W_INIT`, 50: road half-width at level 1.
- `HALF_W_MIN`, 24: floor on road half-width.
- `CX_MIN`, 80 and `CX_MAX`, 720: saturation limits for the road centre.
- `SCRIPT_LEN`, 4: number of bend-script entries. Fixed table is (0,10), (+3,18), (0,10), (−3,18), given as (delta, rows).
- `LEVEL_MAX`, 8: highest level.
- `ROWS_PER_LEVEL`, 56: rows survived per level step.
- `CAR_W`, 30 and `CAR_H`, 30: car box size.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `line_tick` in 1: single-cycle pulse that scrolls the road one row.
- `restart` in 1: single-cycle pulse that leaves DEAD and refills the buffer.
- `car_x` in XW: left x of the car box.
- `car_y` in 9: top y of the car box.
- `rd_row` in 9: row the renderer wants to read.
- `rd_left` out XW: left edge of `rd_row`, registered.
- `rd_right` out XW: right edge of `rd_row`, registered.
- `dead` out 1: a collision has latched.
- `busy` out 1: high in every state except RUN.
- `level` out 4: current level, range 1..LEVEL_MAX.
- `distance` out 16: rows survived, saturating.

## Operation
States: FILL → RUN → DEAD → FILL.
- **Leaving reset:** the block enters FILL on the first clock after `rst` deasserts.

FILL state:
- Writes one buffer entry per clock, addresses 0..ROWS−1, each with CENTER±HALF_W_INIT.
- Takes exactly ROWS cycles, then moves to RUN.
- Entry to FILL clears these to the values shown: head=0, centre=CENTER, deltaX=0, rowsLeft=0, scriptPtr=0, distance=0, level=1, dead=0.
- `line_tick` is ignored in FILL.

RUN state, on each `line_tick`:
- head ← (head−1) mod ROWS. The decrement wraps from 0 to ROWS−1.
- Segment update:
  - If rowsLeft=0, load entry scriptPtr.
  - deltaX ← delta + sign(delta)·level.
  - rowsLeft ← max(rows − 2·level, 1).
  - scriptPtr advances and wraps to 0 after SCRIPT_LEN−1.
  - Otherwise rowsLeft ← rowsLeft − 1.
- centre ← sat(centre + deltaX, CX_MIN, CX_MAX). The sum uses signed XW+1-bit arithmetic.
- halfW = max(HALF_W_INIT − 2·(level−1), HALF_W_MIN).
- Writes {centre−halfW, centre+halfW} at the new head. The centre used is the value before this tick's update.
- distance ← distance+1, saturating at 16'hFFFF.
- When the new distance is a nonzero multiple of ROWS_PER_LEVEL and level<LEVEL_MAX, level increments.

Address mapping:
- Logical row r maps to buffer address (head + r) mod ROWS, on both the renderer port and the collision port.

Collision check:
- Runs on every `line_tick` in RUN.
- Front row f = min(car_y + CAR_H − 1, ROWS−1).
- `dead` latches if car_x < left[f] or car_x + CAR_W − 1 > right[f].
- Both comparisons are unsigned and XW+1 bits wide.
- The state then moves to DEAD.

DEAD state:
- Edges, `level` and `distance` are frozen.
- `dead` stays at 1.
- `restart` moves the state to FILL.

Priority rules:
- `restart` in RUN also moves to FILL, so it aborts the current run.
- `restart` wins over a simultaneous `line_tick`.
- A collision on the same tick as a level-up still applies the level-up, then moves to DEAD.

## Timing
- **Read latency:** `rd_left`/`rd_right` are valid 1 cycle after `rd_row` is presented. The read port is valid in all states.
- **Write vs read:** a write and a read of the same address in one cycle return the old data.
- **Edge write:** the new edge entry and the head update take effect on the clock edge that samples `line_tick`.
- **Collision path:**
  - On the edge after that, the collision row is read.
  - `dead` rises on the second edge after the `line_tick` sample.
  - The state becomes DEAD on that same second edge.
- **Tick spacing:** `line_tick` pulses must be at least 3 cycles apart.
- **Segment, level and distance:** these update on the `line_tick` edge.
- **FILL duration:** ROWS cycles, with `busy`=1 throughout.
- **Reset (`rst`=0), asynchronous and mid-operation included:**
  - dead=0, busy=1, level=1, distance=0.
  - rd_left=0, rd_right=0.
  - State = FILL with the fill counter at 0.
  - Buffer contents are don't-care until the refill completes.

## Test plan
- **Power-up:** release `rst` and wait 480 clocks → `busy` falls on clock 481. Reads of rows 0, 240 and 479 return 414/514.
- **Straight section:** 10 ticks with the car at x=449, y=375 → no `dead`; distance=10; row 0 = 414/514.
- **First bend:** continue ticking into entry 1 → deltaX=4 (3+1) and rowsLeft=16. After tick 11, row 0 centre = 468.
- **Level and narrowing:** tick 56 times with no collision → level becomes 2 on tick 56. The next written row has halfW=48. Level saturates at 8 after 392 ticks, and halfW stays at 36.
- **Collision:** set car_x=400 with front row left edge 414, then tick → `dead`=1 two clocks later. Further ticks do not change distance. `restart` → `busy`=1 for 480 clocks, then dead=0 and level=1.
- **Corner cases:**
  - `restart` coincident with `line_tick` → FILL, and distance stays 0.
  - `rst` asserted mid-FILL → outputs return to reset values asynchronously.
  - car_y=470 → front row clamps to 479.
